axi_master_wr: RTL

// - AXI4 master write engine; the write-side counterpart of the DDR read master. It sits between the

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_master_wr.sv | 122 ++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the DDR read/write masters: engine state encodings and fixed AXI field values.
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WA_WAIT = 3'd1,
        ST_WA      = 3'd2,
        ST_W_WAIT  = 3'd3,
        ST_W       = 3'd4,
        ST_B       = 3'd5
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_master_wr.sv
// AXI4 write master: one INCR burst per wr_start (AW, wr_len+1 W beats, B), data pulled from a show-ahead FIFO.
module axi_master_wr
    import axi_pkg::*;
#(
    parameter int         AXI_WIDTH  = 256,
    parameter logic [2:0] AXI_AXSIZE = 3'b101
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_start,
    input  logic [28:0]            wr_addr,
    input  logic [7:0]             wr_len,
    input  logic [AXI_WIDTH-1:0]   wr_data,
    output logic                   wr_ready,
    output logic                   wr_done,
    output logic                   wr_err,
    output logic                   m_axi_w_handshake,
    output logic [3:0]             m_axi_awid,
    output logic [28:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awlock,
    output logic [3:0]             m_axi_awcache,
    output logic [2:0]             m_axi_awprot,
    output logic [3:0]             m_axi_awqos,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [AXI_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_WIDTH/8-1:0] m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [3:0]             m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready
);

    wr_state_t  state;
    logic [7:0] beat_cnt;
    logic       w_hs;
    logic       unused_bid;

    assign unused_bid = ^m_axi_bid;

    assign m_axi_awid    = '0;
    assign m_axi_awsize  = AXI_AXSIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEF;
    assign m_axi_awprot  = '0;
    assign m_axi_awqos   = '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = wr_data;

    assign w_hs              = m_axi_wvalid & m_axi_wready;
    assign m_axi_w_handshake = w_hs;
    assign m_axi_wlast       = m_axi_wvalid & (beat_cnt == m_axi_awlen);
    assign wr_ready          = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            beat_cnt      <= '0;
            wr_done       <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_start) state <= ST_WA_WAIT;
                end
                ST_WA_WAIT: begin
                    m_axi_awaddr  <= wr_addr;
                    m_axi_awlen   <= wr_len;
                    m_axi_awvalid <= 1'b1;
                    state         <= ST_WA;
                end
                ST_WA: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= ST_W_WAIT;
                    end
                end
                ST_W_WAIT: begin
                    beat_cnt     <= '0;
                    m_axi_wvalid <= 1'b1;
                    state        <= ST_W;
                end
                ST_W: begin
                    // The last beat leaves beat_cnt at awlen so a 256-beat burst never wraps.
                    if (w_hs) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= ST_B;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        wr_done      <= 1'b1;
                        wr_err       <= (m_axi_bresp != AXI_RESP_OKAY);
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
